// File: rtl/ram_sync_param.sv
// ram_sync_param: parametrised single-port synchronous RAM.
// Separate write and read data buses and a req/ready handshake.
// The read pipeline is 1 or 2 stages deep (RD_LAT).
// An optional clear sweep zeroes every word after reset.
// An auto-increment pointer supports sequential access.
module ram_sync_param #(
    parameter int DATA_W         = 4,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 1 << ADDR_W,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              auto_inc,
    input  logic              ptr_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] ptr
);

    // DEPTH can equal 2**ADDR_W. Range checks are therefore done one bit wider.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_rd_acc;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_ea;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_data;

    assign ready      = (r_state == ST_RUN);
    assign w_accept   = req && ready;
    assign w_rd_acc   = w_accept && !we;
    assign w_ea       = auto_inc ? r_ptr : addr;
    assign w_in_range = ({1'b0, w_ea} < DEPTH_X);
    assign w_rd_word  = w_in_range ? r_mem[w_ea] : '0;
    assign ptr        = r_ptr;

    // State register and clear-sweep counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            // NOTE: registered state uses <= so every flop samples pre-edge values.
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR once the last word has been zeroed
    always_comb begin
        // NOTE: default first, so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        if ((r_state == ST_CLEAR) && (r_cnt == LAST)) begin
            w_next_state = ST_RUN;
        end
    end

    // Write-port mux: the clear sweep owns the port, then accepted in-range writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_ea;
        w_mem_wdata = wdata;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
        end else if (w_accept && we && w_in_range) begin
            w_mem_we = 1'b1;
        end
    end

    // Storage array
    // NOTE: no reset term here. The array maps to RAM, and zeroing is the clear sweep's job.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Address pointer: a load beats the increment, and both are ignored while clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (ready) begin
            if (ptr_ld) begin
                r_ptr <= ({1'b0, addr} < DEPTH_X) ? addr : '0;
            end else if (w_accept && auto_inc) begin
                r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    // First read stage: capture the word at the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_vld;
            logic [DATA_W-1:0] r_s2_data;

            // Second read stage: data updates only on a completing read, so it holds otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_vld  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rvalid = r_s2_vld;
            assign rdata  = r_s2_data;
        end else begin : g_lat1
            assign rvalid = r_s1_vld;
            assign rdata  = r_s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_param.sv
// tb_ram_sync_param: self-checking bench for ram_sync_param.
// Two instances share all inputs:
//   A: DEPTH=256, RD_LAT=1
//   B: DEPTH=200, RD_LAT=2
// Each instance is compared every cycle against its own behavioural model.
// The model is a word array, an integer pointer and a schedule of read completions.
module tb_ram_sync_param;

    localparam int NI = 2;
    localparam int DEPTH_K [NI] = '{256, 200};
    localparam int LAT_K   [NI] = '{1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, we, auto_inc, ptr_ld;
    logic [7:0] addr;
    logic [3:0] wdata;

    logic       ready_a, rvalid_a, ready_b, rvalid_b;
    logic [3:0] rdata_a, rdata_b;
    logic [7:0] ptr_a, ptr_b;

    always #5 clk = ~clk;

    ram_sync_param #(
        .DATA_W(4), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .auto_inc(auto_inc),
        .ptr_ld(ptr_ld), .addr(addr), .wdata(wdata), .ready(ready_a),
        .rdata(rdata_a), .rvalid(rvalid_a), .ptr(ptr_a)
    );

    ram_sync_param #(
        .DATA_W(4), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .auto_inc(auto_inc),
        .ptr_ld(ptr_ld), .addr(addr), .wdata(wdata), .ready(ready_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .ptr(ptr_b)
    );

    // Reference model state
    logic [3:0] m_mem      [NI][256];
    int         m_ptr      [NI];
    int         m_clr_left [NI];
    logic [3:0] m_rdata    [NI];
    logic       sched_v    [NI][4];
    logic [3:0] sched_d    [NI][4];
    int         cyc;

    // Sampled DUT outputs
    logic       o_ready  [NI];
    logic       o_rvalid [NI];
    logic [3:0] o_rdata  [NI];
    logic [7:0] o_ptr    [NI];

    int n_vec;
    int n_err;

    task automatic drive(input logic r, input logic w, input logic ai, input logic ld,
                         input logic [7:0] a, input logic [3:0] d);
        req = r; we = w; auto_inc = ai; ptr_ld = ld; addr = a; wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic sample();
        o_ready[0] = ready_a;  o_rvalid[0] = rvalid_a;  o_rdata[0] = rdata_a;  o_ptr[0] = ptr_a;
        o_ready[1] = ready_b;  o_rvalid[1] = rvalid_b;  o_rdata[1] = rdata_b;  o_ptr[1] = ptr_b;
    endtask

    // Apply the current inputs to the model, clock once, then compare both instances
    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            int ea;
            int due;
            if (m_clr_left[k] > 0) begin
                m_mem[k][DEPTH_K[k] - m_clr_left[k]] = 4'h0;
                m_clr_left[k]--;
            end else begin
                ea = auto_inc ? m_ptr[k] : int'(addr);
                if (req) begin
                    if (we) begin
                        if (ea < DEPTH_K[k]) m_mem[k][ea] = wdata;
                    end else begin
                        due = (cyc + LAT_K[k]) % 4;
                        sched_v[k][due] = 1'b1;
                        sched_d[k][due] = (ea < DEPTH_K[k]) ? m_mem[k][ea] : 4'h0;
                    end
                end
                if (ptr_ld) m_ptr[k] = (int'(addr) >= DEPTH_K[k]) ? 0 : int'(addr);
                else if (req && auto_inc) m_ptr[k] = (m_ptr[k] + 1) % DEPTH_K[k];
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        sample();
        for (int k = 0; k < NI; k++) begin
            int   slot;
            logic exp_v;
            slot  = cyc % 4;
            exp_v = sched_v[k][slot];
            sched_v[k][slot] = 1'b0;
            if (exp_v) m_rdata[k] = sched_d[k][slot];
            n_vec++;
            if (o_ready[k] !== (m_clr_left[k] == 0)) begin
                n_err++;
                $display("FAIL ready[%0d] cyc %0d: got %b want %b", k, cyc, o_ready[k], m_clr_left[k] == 0);
            end
            n_vec++;
            if (o_rvalid[k] !== exp_v) begin
                n_err++;
                $display("FAIL rvalid[%0d] cyc %0d: got %b want %b", k, cyc, o_rvalid[k], exp_v);
            end
            n_vec++;
            if (o_rdata[k] !== m_rdata[k]) begin
                n_err++;
                $display("FAIL rdata[%0d] cyc %0d: got %h want %h", k, cyc, o_rdata[k], m_rdata[k]);
            end
            n_vec++;
            if (o_ptr[k] !== 8'(m_ptr[k])) begin
                n_err++;
                $display("FAIL ptr[%0d] cyc %0d: got %h want %h", k, cyc, o_ptr[k], 8'(m_ptr[k]));
            end
        end
    endtask

    // Assert reset away from the clock edge and check the reset values while it is held
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_ptr[k]      = 0;
            m_rdata[k]    = 4'h0;
            m_clr_left[k] = DEPTH_K[k];
            for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
        end
        #1;
        sample();
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (o_ready[k] !== 1'b0 || o_rvalid[k] !== 1'b0 || o_rdata[k] !== 4'h0 || o_ptr[k] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_vals[%0d]: got ready=%b rvalid=%b rdata=%h ptr=%h want 0 0 0 00",
                         k, o_ready[k], o_rvalid[k], o_rdata[k], o_ptr[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count idle cycles until each instance raises ready, bounded
    task automatic wait_ready(input int exp_a, input int exp_b);
        int first [NI];
        first[0] = -1;
        first[1] = -1;
        idle();
        for (int i = 1; i <= 300; i++) begin
            tick();
            for (int k = 0; k < NI; k++) if (first[k] < 0 && o_ready[k] === 1'b1) first[k] = i;
            if (first[0] > 0 && first[1] > 0) break;
        end
        n_vec++;
        if (first[0] != exp_a) begin
            n_err++;
            $display("FAIL clear_len[0]: got %0d want %0d", first[0], exp_a);
        end
        n_vec++;
        if (first[1] != exp_b) begin
            n_err++;
            $display("FAIL clear_len[1]: got %0d want %0d", first[1], exp_b);
        end
    endtask

    task automatic test_reset();
        do_reset();
        wait_ready(256, 200);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 4'h0);
        tick();
        idle();
        n_vec++;
        if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== 4'h0) begin
            n_err++;
            $display("FAIL t1_read7f_a: got rvalid=%b rdata=%h want 1 0", o_rvalid[0], o_rdata[0]);
        end
        tick();
        n_vec++;
        if (o_rvalid[1] !== 1'b1 || o_rdata[1] !== 4'h0) begin
            n_err++;
            $display("FAIL t1_read7f_b: got rvalid=%b rdata=%h want 1 0", o_rvalid[1], o_rdata[1]);
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 4'hA);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0);
        tick();
        idle();
        n_vec++;
        if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== 4'hA || o_rvalid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL t2_lat1: got a.rvalid=%b a.rdata=%h b.rvalid=%b want 1 a 0",
                     o_rvalid[0], o_rdata[0], o_rvalid[1]);
        end
        tick();
        n_vec++;
        if (o_rvalid[0] !== 1'b0 || o_rdata[0] !== 4'hA || o_rvalid[1] !== 1'b1 || o_rdata[1] !== 4'hA) begin
            n_err++;
            $display("FAIL t2_lat2: got a.rvalid=%b a.rdata=%h b.rvalid=%b b.rdata=%h want 0 a 1 a",
                     o_rvalid[0], o_rdata[0], o_rvalid[1], o_rdata[1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 4'h3);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 4'h0);
        tick();
        n_vec++;
        if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== 4'h3) begin
            n_err++;
            $display("FAIL t3_first_a: got rvalid=%b rdata=%h want 1 3", o_rvalid[0], o_rdata[0]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 4'h0);
        tick();
        idle();
        n_vec++;
        if (o_rvalid[0] !== 1'b1 || o_rdata[0] !== 4'h0 || o_rvalid[1] !== 1'b1 || o_rdata[1] !== 4'h3) begin
            n_err++;
            $display("FAIL t3_second: got a=%b/%h b=%b/%h want 1/0 1/3",
                     o_rvalid[0], o_rdata[0], o_rvalid[1], o_rdata[1]);
        end
        tick();
        n_vec++;
        if (o_rvalid[1] !== 1'b1 || o_rdata[1] !== 4'h0) begin
            n_err++;
            $display("FAIL t3_third_b: got rvalid=%b rdata=%h want 1 0", o_rvalid[1], o_rdata[1]);
        end
        tick();
    endtask

    task automatic test_pointer();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 4'h0);
        tick();
        n_vec++;
        if (o_ptr[0] !== 8'hFE || o_ptr[1] !== 8'h00) begin
            n_err++;
            $display("FAIL t4_ptr_ld: got a=%h b=%h want fe 00", o_ptr[0], o_ptr[1]);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'(i));
            tick();
        end
        n_vec++;
        if (o_ptr[0] !== 8'h01 || o_ptr[1] !== 8'h03) begin
            n_err++;
            $display("FAIL t4_ptr_wrap: got a=%h b=%h want 01 03", o_ptr[0], o_ptr[1]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 4'h0);
        tick();
        n_vec++;
        if (o_rdata[0] !== 4'h1) begin
            n_err++;
            $display("FAIL t4_mem_fe: got %h want 1", o_rdata[0]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4'h0);
        tick();
        n_vec++;
        if (o_rdata[0] !== 4'h2) begin
            n_err++;
            $display("FAIL t4_mem_ff: got %h want 2", o_rdata[0]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        tick();
        n_vec++;
        if (o_rdata[0] !== 4'h3) begin
            n_err++;
            $display("FAIL t4_mem_00: got %h want 3", o_rdata[0]);
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hC8, 4'h9);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hC8, 4'h0);
        tick();
        idle();
        tick();
        n_vec++;
        if (o_rvalid[1] !== 1'b1 || o_rdata[1] !== 4'h0) begin
            n_err++;
            $display("FAIL t5_oor_read: got rvalid=%b rdata=%h want 1 0", o_rvalid[1], o_rdata[1]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC8, 4'h0);
        tick();
        n_vec++;
        if (o_ptr[1] !== 8'h00 || o_ptr[0] !== 8'hC8) begin
            n_err++;
            $display("FAIL t5_ptr_clamp: got b=%h a=%h want 00 c8", o_ptr[1], o_ptr[0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC7, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
        tick();
        n_vec++;
        if (o_ptr[1] !== 8'h00 || o_ptr[0] !== 8'hC8) begin
            n_err++;
            $display("FAIL t5_ptr_wrap: got b=%h a=%h want 00 c8", o_ptr[1], o_ptr[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 4'h0);
        tick();
        n_vec++;
        if (o_ptr[1] !== 8'h20 || o_ptr[0] !== 8'h20) begin
            n_err++;
            $display("FAIL t5_ld_beats_inc: got b=%h a=%h want 20 20", o_ptr[1], o_ptr[0]);
        end
        idle();
        tick();
        tick();
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(0, 255));
            1:       return 8'($urandom_range(195, 205));
            2:       return 8'($urandom_range(250, 259) % 256);
            default: return 8'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom % 2), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0, pick_addr(), 4'($urandom % 16));
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        idle();
        for (int i = 0; i < 100; i++) tick();
        do_reset();
        wait_ready(256, 200);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0);
        tick();
        idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (o_rvalid[1] !== 1'b0) begin
                n_err++;
                $display("FAIL t6_flushed_b: got rvalid=%b want 0", o_rvalid[1]);
            end
        end
        wait_ready(253, 197);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        idle();
        for (int k = 0; k < NI; k++) begin
            m_ptr[k]      = 0;
            m_rdata[k]    = 4'h0;
            m_clr_left[k] = DEPTH_K[k];
            for (int s = 0; s < 4; s++) begin
                sched_v[k][s] = 1'b0;
                sched_d[k][s] = 4'h0;
            end
            for (int a = 0; a < 256; a++) m_mem[k][a] = 4'h0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_pointer();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
